// File: rtl/telemetry_tx.sv
// Periodic UART telemetry framer: 8N1 packets of sync bytes plus battery/current/torque snapshots.
// Define TELEM_CHKSUM_EN to append an inverted modulo-256 checksum byte over bytes 2..7.
module telemetry_tx #(
  parameter int FAST_SIM = 0,
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] batt,
  input  logic [11:0] curr,
  input  logic [11:0] torque,
  input  logic        en,
  output logic        TX,
  output logic        busy,
  output logic        pkt_done,
  output logic [1:0]  o_dbg_state
);

  localparam logic [21:0] WAIT_TC = (FAST_SIM != 0) ? 22'd511 : 22'h3F_FFFF;
  localparam logic [11:0] BAUD_TC = 12'(BAUD_DIV - 1);
`ifdef TELEM_CHKSUM_EN
  localparam logic [3:0]  LAST_BYTE = 4'd8;
`else
  localparam logic [3:0]  LAST_BYTE = 4'd7;
`endif

  typedef enum logic [1:0] {S_WAIT, S_START, S_DATA, S_STOP} state_t;

  state_t      r_state, w_state_nxt;
  logic [21:0] r_wait, w_wait_nxt;
  logic [11:0] r_baud, w_baud_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [3:0]  r_byte, w_byte_nxt;
  logic [11:0] r_batt, r_curr, r_torque;
  logic        r_tx, r_busy, r_done;
  logic        w_tx_nxt, w_busy_nxt, w_done_nxt;
  logic        w_cap, w_baud_tc;
  logic [7:0]  w_cur_byte;
`ifdef TELEM_CHKSUM_EN
  logic [7:0]  w_chk;
  assign w_chk = ~({4'h0, r_batt[11:8]} + r_batt[7:0] + {4'h0, r_curr[11:8]}
                   + r_curr[7:0] + {4'h0, r_torque[11:8]} + r_torque[7:0]);
`endif

  assign w_baud_tc   = (r_baud == BAUD_TC);
  assign TX          = r_tx;
  assign busy        = r_busy;
  assign pkt_done    = r_done;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_WAIT;
      r_wait   <= '0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
      r_batt   <= '0;
      r_curr   <= '0;
      r_torque <= '0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_byte  <= w_byte_nxt;
      if (w_cap) begin
        r_batt   <= batt;
        r_curr   <= curr;
        r_torque <= torque;
      end
      r_tx   <= w_tx_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit;
    w_byte_nxt  = r_byte;
    w_cap       = 1'b0;
    if (r_state != S_WAIT) w_baud_nxt = w_baud_tc ? 12'd0 : r_baud + 12'd1;
    case (r_state)
      S_WAIT: begin
        if (!en) begin
          w_wait_nxt = '0;
        end else if (r_wait == WAIT_TC) begin
          w_wait_nxt  = '0;
          w_cap       = 1'b1;
          w_byte_nxt  = '0;
          w_bit_nxt   = '0;
          w_baud_nxt  = '0;
          w_state_nxt = S_START;
        end else begin
          w_wait_nxt = r_wait + 22'd1;
        end
      end
      S_START: if (w_baud_tc) begin
        w_bit_nxt   = '0;
        w_state_nxt = S_DATA;
      end
      S_DATA: if (w_baud_tc) begin
        if (r_bit == 3'd7) w_state_nxt = S_STOP;
        else               w_bit_nxt   = r_bit + 3'd1;
      end
      S_STOP: if (w_baud_tc) begin
        if (r_byte == LAST_BYTE) begin
          w_wait_nxt  = '0;
          w_state_nxt = S_WAIT;
        end else begin
          w_byte_nxt  = r_byte + 4'd1;
          w_state_nxt = S_START;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // Byte mux reads the snapshot only, so live inputs never reach the line mid-packet.
  always_comb begin
    w_cur_byte = 8'hAA;
    case (w_byte_nxt)
      4'd0:    w_cur_byte = 8'hAA;
      4'd1:    w_cur_byte = 8'h55;
      4'd2:    w_cur_byte = {4'h0, r_batt[11:8]};
      4'd3:    w_cur_byte = r_batt[7:0];
      4'd4:    w_cur_byte = {4'h0, r_curr[11:8]};
      4'd5:    w_cur_byte = r_curr[7:0];
      4'd6:    w_cur_byte = {4'h0, r_torque[11:8]};
      4'd7:    w_cur_byte = r_torque[7:0];
`ifdef TELEM_CHKSUM_EN
      4'd8:    w_cur_byte = w_chk;
`endif
      default: w_cur_byte = 8'hAA;
    endcase
  end

  // Outputs are decoded from the next state and registered, keeping TX glitch-free.
  always_comb begin
    w_busy_nxt = (w_state_nxt != S_WAIT);
    w_done_nxt = (r_state == S_STOP) && (w_state_nxt == S_WAIT);
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_cur_byte[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule
